// File: rtl/axi_wr_buffer_pkg.sv
// Shared definitions for the posted-write buffer: AXI field constants,
// the drain FSM state type and the buffered store entry layout.
package axi_wr_buffer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_1B    = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B    = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_SEND,
    DRAIN_WAIT_B
  } drain_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } st_entry_t;

  // Pipeline size code (0=byte,1=half,2=word) to AXI awsize.
  function automatic logic [2:0] axi_size(input logic [1:0] s);
    case (s)
      2'd0:    return AXI_SIZE_1B;
      2'd1:    return AXI_SIZE_2B;
      2'd2:    return AXI_SIZE_4B;
      default: return {1'b0, s};
    endcase
  endfunction

endpackage

// File: rtl/axi_wr_buffer_if.sv
// AXI write-channel bundle (AW, W, B) between the buffer and the bus.
interface axi_wr_buffer_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_buffer_wr_fifo.sv
// Store FIFO: entry storage, wrapping pointers, occupancy count and a
// parallel word-address compare across all occupied entries.
module axi_wr_buffer_wr_fifo
  import axi_wr_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  st_entry_t        push_entry,
  input  logic             pop,
  output st_entry_t        head_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  input  logic [31:0]      chk_addr,
  output logic             chk_hit
);

  st_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [DEPTH-1:0] hit_vec;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = mem[head];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // An entry is live when its distance from head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic [PTR_W-1:0] offs;
    assign offs        = PTR_W'(gi) - head;
    assign hit_vec[gi] = ({1'b0, offs} < count) &&
                         (mem[gi].addr[31:2] == chk_addr[31:2]);
  end

  assign chk_hit = |hit_vec;

endmodule

// File: rtl/axi_wr_buffer.sv
// Posted-write buffer: acknowledges stores at once, then drains them one
// at a time over AXI AW/W/B with a single outstanding transaction.
module axi_wr_buffer
  import axi_wr_buffer_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            st_req,
  input  logic [1:0]      st_size,
  input  logic [3:0]      st_wstrb,
  input  logic [31:0]     st_addr,
  input  logic [31:0]     st_wdata,
  output logic            st_addr_ok,
  output logic            st_data_ok,
  input  logic [31:0]     chk_addr,
  output logic            chk_hit,
  output logic            wb_empty,
  output logic            bus_err,
  axi_wr_buffer_if.master axi
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  st_entry_t        push_entry;
  st_entry_t        head_entry;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  drain_state_t     state, state_nxt;
  logic             aw_done, w_done, aw_done_nxt, w_done_nxt;
  logic             awvalid, wvalid, bready;
  logic             unused_bid;

  assign push       = st_req & ~full;
  assign st_addr_ok = ~full;
  assign wb_empty   = empty;
  assign push_entry = '{addr: st_addr, size: st_size, wstrb: st_wstrb, wdata: st_wdata};
  assign unused_bid = ^axi.bid;

  axi_wr_buffer_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .chk_addr   (chk_addr),
    .chk_hit    (chk_hit)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= DRAIN_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      bus_err    <= 1'b0;
      st_data_ok <= 1'b0;
    end else begin
      state      <= state_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
      bus_err    <= bus_err | (bready & axi.bvalid & (axi.bresp != AXI_RESP_OKAY));
      st_data_ok <= push;
    end
  end

  // A push into an idle buffer starts the drain next cycle, so the first
  // awvalid appears the cycle after the store is accepted.
  always_comb begin
    state_nxt   = state;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    pop         = 1'b0;
    unique case (state)
      DRAIN_IDLE: begin
        if (!empty || push) state_nxt = DRAIN_SEND;
      end
      DRAIN_SEND: begin
        awvalid     = ~aw_done;
        wvalid      = ~w_done;
        aw_done_nxt = aw_done | axi.awready;
        w_done_nxt  = w_done | axi.wready;
        if (aw_done_nxt && w_done_nxt) state_nxt = DRAIN_WAIT_B;
      end
      DRAIN_WAIT_B: begin
        bready = 1'b1;
        if (axi.bvalid) begin
          pop         = 1'b1;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = (count > CNT_W'(1) || push) ? DRAIN_SEND : DRAIN_IDLE;
        end
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
  end

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = head_entry.addr;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = axi_size(head_entry.size);
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = head_entry.wdata;
  assign axi.wstrb   = head_entry.wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready;

endmodule

// File: tb/tb_axi_wr_buffer.sv
// Scoreboard bench for axi_wr_buffer: a queue model of the posted stores
// predicts acceptance, drain order, AXI payloads, chk_hit and bus_err.
module tb_axi_wr_buffer;
  import axi_wr_buffer_pkg::*;

  localparam int         DEPTH  = 4;
  localparam logic [3:0] AXI_ID = 4'd1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        st_req = 1'b0;
  logic [1:0]  st_size = '0;
  logic [3:0]  st_wstrb = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic        st_addr_ok, st_data_ok, chk_hit, wb_empty, bus_err;
  logic [31:0] chk_addr = '0;

  axi_wr_buffer_if axi();

  axi_wr_buffer #(.DEPTH(DEPTH), .AXI_ID(AXI_ID)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .st_req     (st_req),
    .st_size    (st_size),
    .st_wstrb   (st_wstrb),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .st_addr_ok (st_addr_ok),
    .st_data_ok (st_data_ok),
    .chk_addr   (chk_addr),
    .chk_hit    (chk_hit),
    .wb_empty   (wb_empty),
    .bus_err    (bus_err),
    .axi        (axi.master)
  );

  initial forever #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_aw[$];
  txn_t        exp_w[$];
  logic [31:0] out_q[$];
  logic [1:0]  bresp_q[$];

  int          n_cmp = 0, n_err = 0;
  int          model_cnt = 0;
  bit          model_err = 0, push_acc = 0, exp_dok = 0, b_hs_pend = 0;
  logic [31:0] push_addr;
  int          aw_cnt = 0, w_cnt = 0, b_done = 0, b_raised = 0;
  int          aw_mode = 0, w_mode = 0, b_mode = 0;
  bit          chk_rand = 0;
  bit          aw_stall = 0, w_stall = 0;
  logic [31:0] stall_awaddr, stall_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mode_val(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) return logic'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic tb_reset();
    exp_aw.delete(); exp_w.delete(); out_q.delete(); bresp_q.delete();
    model_cnt = 0; model_err = 0; push_acc = 0; exp_dok = 0; b_hs_pend = 0;
    aw_cnt = 0; w_cnt = 0; b_done = 0; b_raised = 0;
    aw_stall = 0; w_stall = 0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    st_req = 1'b0;
  endtask

  // Model update at each active edge: retire a B'd entry, admit a push.
  initial forever begin
    @(posedge aclk);
    if (b_hs_pend) begin
      void'(out_q.pop_front());
      model_cnt--;
      b_hs_pend = 0;
    end
    exp_dok = push_acc;
    if (push_acc) begin
      out_q.push_back(push_addr);
      model_cnt++;
      push_acc = 0;
    end
  end

  // AXI slave responder plus random load-address probe.
  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = AXI_ID;
    forever begin
      @(posedge aclk); #1;
      axi.awready = mode_val(aw_mode);
      axi.wready  = mode_val(w_mode);
      if (axi.bvalid && b_done == b_raised) axi.bvalid = 1'b0;
      if (!axi.bvalid && ((aw_cnt < w_cnt ? aw_cnt : w_cnt) > b_raised) &&
          (b_mode == 0 || (b_mode == 1 && $urandom_range(0, 1) == 1))) begin
        axi.bvalid = 1'b1;
        b_raised++;
        axi.bresp = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
      end
      if (chk_rand)
        chk_addr = 32'h3000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    end
  end

  // Monitor: compare every output against the model away from the edge.
  initial begin
    txn_t t;
    bit   hit;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        check("st_data_ok", st_data_ok, exp_dok);
        check("wb_empty", wb_empty, model_cnt == 0);
        check("bus_err", bus_err, model_err);
        check("st_addr_ok", st_addr_ok, model_cnt < DEPTH);
        hit = 0;
        foreach (out_q[i]) if (out_q[i][31:2] == chk_addr[31:2]) hit = 1;
        check("chk_hit", chk_hit, hit);
        if (aw_stall) begin
          check("awvalid_hold", axi.awvalid, 1);
          check("awaddr_hold", axi.awaddr, stall_awaddr);
        end
        if (w_stall) begin
          check("wvalid_hold", axi.wvalid, 1);
          check("wdata_hold", axi.wdata, stall_wdata);
        end
        aw_stall = axi.awvalid && !axi.awready;
        w_stall  = axi.wvalid && !axi.wready;
        stall_awaddr = axi.awaddr;
        stall_wdata  = axi.wdata;
        if (axi.awvalid && axi.awready) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
          else begin
            t = exp_aw.pop_front();
            check("awaddr", axi.awaddr, t.addr);
            check("awsize", axi.awsize, {1'b0, t.size});
            check("awid", axi.awid, AXI_ID);
            check("awlen", axi.awlen, 0);
            check("awburst", axi.awburst, 1);
            check("aw_lock_cache_prot", {axi.awlock, axi.awcache, axi.awprot}, 0);
          end
          aw_cnt++;
        end
        if (axi.wvalid && axi.wready) begin
          if (exp_w.size() == 0) check("w_unexpected", 1, 0);
          else begin
            t = exp_w.pop_front();
            check("wdata", axi.wdata, t.data);
            check("wstrb", axi.wstrb, t.strb);
            check("wlast", axi.wlast, 1);
            check("wid", axi.wid, AXI_ID);
          end
          w_cnt++;
        end
        if (axi.bvalid && axi.bready) begin
          if (axi.bresp != 2'b00) model_err = 1;
          b_done++;
          b_hs_pend = 1;
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [1:0] sz,
                      input logic [3:0] sb, input logic [31:0] d);
    bit   done = 0;
    txn_t t;
    t.addr = a; t.size = sz; t.strb = sb; t.data = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge aclk); #1;
      st_req = 1'b1; st_addr = a; st_size = sz; st_wstrb = sb; st_wdata = d;
      @(negedge aclk);
      check("st_addr_ok_push", st_addr_ok, model_cnt < DEPTH);
      if (model_cnt < DEPTH) begin
        done = 1;
        push_acc = 1;
        push_addr = a;
        exp_aw.push_back(t);
        exp_w.push_back(t);
      end
    end
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
      st_req = 1'b0;
      @(negedge aclk);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (k < budget && (model_cnt != 0 || push_acc)) begin
      idle(1);
      k++;
    end
    check("drain_done", model_cnt == 0 && !push_acc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_st_addr_ok", st_addr_ok, 1);
    check("rst_st_data_ok", st_data_ok, 0);
    check("rst_chk_hit", chk_hit, 0);
    check("rst_wb_empty", wb_empty, 1);
    check("rst_bus_err", bus_err, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_bready", axi.bready, 0);
    check("rst_awaddr", axi.awaddr, 0);
    check("rst_wdata", axi.wdata, 0);
    @(posedge aclk); #2; aresetn = 1'b1;
    idle(2);

    // Single store, minimum latency
    push(32'h1000_0040, 2'd2, 4'hF, 32'hDEAD_BEEF);
    idle(1);
    check("t1_data_ok", st_data_ok, 1);
    check("t1_awvalid", axi.awvalid, 1);
    check("t1_wvalid", axi.wvalid, 1);
    check("t1_awsize", axi.awsize, 2);
    check("t1_wlast", axi.wlast, 1);
    check("t1_awaddr", axi.awaddr, 32'h1000_0040);
    idle(1);
    check("t1_bready", axi.bready, 1);
    check("t1_awvalid_low", axi.awvalid, 0);
    idle(1);
    check("t1_wb_empty", wb_empty, 1);
    idle(2);

    // Fill with AW blocked, fifth store waits for the first B
    aw_mode = 2;
    for (int i = 0; i < 4; i++)
      push(32'h1100_0000 + 32'(i * 4), 2'd2, 4'hF, 32'hA000_0000 + 32'(i));
    idle(1);
    check("t2_full", st_addr_ok, 0);
    idle(2);
    aw_mode = 0;
    push(32'h1100_0010, 2'd1, 4'h3, 32'h0000_5555);
    idle(1);
    wait_drain(100);
    idle(2);

    // AW/W skew: W accepted at once, AW three cycles later
    aw_mode = 2;
    idle(1);
    push(32'h1200_0000, 2'd0, 4'h4, 32'h00AB_0000);
    idle(1);
    check("t3_awvalid_n1", axi.awvalid, 1);
    check("t3_wvalid_n1", axi.wvalid, 1);
    idle(1);
    check("t3_wvalid_n2", axi.wvalid, 0);
    check("t3_awvalid_n2", axi.awvalid, 1);
    check("t3_bready_n2", axi.bready, 0);
    idle(1);
    check("t3_bready_n3", axi.bready, 0);
    aw_mode = 0;
    idle(1);
    check("t3_awvalid_n4", axi.awvalid, 1);
    check("t3_awaddr_n4", axi.awaddr, 32'h1200_0000);
    check("t3_bready_n4", axi.bready, 0);
    idle(1);
    check("t3_bready_n5", axi.bready, 1);
    wait_drain(50);
    idle(2);

    // Load/store address check
    aw_mode = 2;
    idle(1);
    push(32'h2000_0104, 2'd2, 4'hF, 32'h1234_5678);
    idle(1);
    @(posedge aclk); #1; chk_addr = 32'h2000_0106; @(negedge aclk);
    check("t4_hit_same_word", chk_hit, 1);
    @(posedge aclk); #1; chk_addr = 32'h2000_0108; @(negedge aclk);
    check("t4_miss_next_word", chk_hit, 0);
    @(posedge aclk); #1; chk_addr = 32'h2000_0106; aw_mode = 0; @(negedge aclk);
    k = 0;
    while (k < 30 && !(axi.bvalid && axi.bready)) begin idle(1); k++; end
    check("t4_b_seen", axi.bvalid && axi.bready, 1);
    idle(1);
    check("t4_hit_cleared", chk_hit, 0);
    idle(2);

    // Error response on the first of two stores
    bresp_q.push_back(2'b10);
    push(32'h2100_0000, 2'd2, 4'hF, 32'hCAFE_0001);
    push(32'h2100_0004, 2'd2, 4'hF, 32'hCAFE_0002);
    idle(1);
    wait_drain(60);
    idle(3);
    check("t5_bus_err_sticky", bus_err, 1);

    // Reset while waiting for B with three entries buffered
    b_mode = 2;
    for (int i = 0; i < 3; i++)
      push(32'h2200_0000 + 32'(i * 4), 2'd2, 4'hF, 32'hBB00_0000 + 32'(i));
    idle(1);
    k = 0;
    while (k < 30 && axi.bready !== 1'b1) begin idle(1); k++; end
    check("t6_in_wait_b", axi.bready, 1);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check("t6_awvalid", axi.awvalid, 0);
    check("t6_wvalid", axi.wvalid, 0);
    check("t6_bready", axi.bready, 0);
    check("t6_wb_empty", wb_empty, 1);
    check("t6_bus_err", bus_err, 0);
    tb_reset();
    b_mode = 0;
    repeat (2) @(posedge aclk);
    #2; aresetn = 1'b1;
    idle(1);
    push(32'h2300_0000, 2'd1, 4'hC, 32'h7777_0000);
    idle(1);
    wait_drain(40);
    idle(2);

    // Randomized traffic
    chk_rand = 1;
    for (int it = 0; it < 300; it++) begin
      if (it % 25 == 0) begin
        aw_mode = $urandom_range(0, 1);
        w_mode  = $urandom_range(0, 1);
        b_mode  = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 15) == 0) bresp_q.push_back(2'b10);
      if ($urandom_range(0, 2) == 0)
        push(32'h3000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
             2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), $urandom);
      else
        idle(1);
    end
    idle(1);
    aw_mode = 0; w_mode = 0; b_mode = 0;
    wait_drain(200);
    idle(3);
    check("end_aw_queue_empty", exp_aw.size(), 0);
    check("end_w_queue_empty", exp_w.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_wr_buffer.md
# axi_wr_buffer

Posted-write buffer and AXI write-channel scheduler for the data side of the CPU. Stores issued by the memory pipeline are accepted into a small FIFO and acknowledged immediately. The FIFO drains one at a time onto the AXI AW/W/B channels. A combinational address check lets the load path stall a read that would overtake a buffered write to the same word. The block sits between exe/mem-stage store requests and the AXI write master ports of the top level; the read path is untouched.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- AXI_ID, 4'd1, value driven on awid/wid
- aclk  in  1  clock, all state on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- st_req  in  1  store request valid
- st_size  in  2  0=byte, 1=half, 2=word
- st_wstrb  in  4  byte enables
- st_addr  in  32  physical byte address
- st_wdata  in  32  store data, lane-aligned
- st_addr_ok  out  1  request accepted this cycle when st_req high
- st_data_ok  out  1  one-cycle pulse, posted-write completion to pipeline
- chk_addr  in  32  load address to check
- chk_hit  out  1  a buffered or in-flight store matches chk_addr[31:2]
- wb_empty  out  1  no buffered or in-flight store
- bus_err  out  1  sticky, a B response was not OKAY
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI write address
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
- wready  in  1
- bid  in  4;  bresp  in  2;  bvalid  in  1;  bready  out  1

## Operation
- FIFO: head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits. Each entry holds {addr, size, wstrb, wdata}.
- st_addr_ok = (count < DEPTH). A push happens on st_req & st_addr_ok. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- The head entry stays in the FIFO until its B handshake. It counts toward count and toward chk_hit.
- Drain FSM states:
  - IDLE: go to SEND when count≠0.
  - SEND: awvalid and wvalid are both driven from the head entry. Each is held until its own ready, tracked by aw_done and w_done flags. AW and W may complete in either order or in the same cycle. When both are done, go to WAIT_B.
  - WAIT_B: bready=1. On bvalid, pop the head and clear the flags. Then go to SEND if count>1 before the pop, otherwise go to IDLE.
- Only one write transaction is outstanding at a time.
- Fixed AXI fields: awlen=0, awburst=2'b01, awlock=0, awcache=0, awprot=0, wlast=1.
- awsize = {1'b0, st_size}.
- awaddr and wstrb are passed through unmodified.
- bid is ignored.
- bresp≠0 still pops the entry and sets bus_err.
- chk_hit = OR over all valid entries of (entry.addr[31:2] == chk_addr[31:2]). It is purely combinational.
- wb_empty = (count == 0).

## Timing
- Reset values:
  - st_addr_ok=1, st_data_ok=0, chk_hit=0, wb_empty=1, bus_err=0.
  - awvalid=0, wvalid=0, bready=0.
  - FSM in IDLE, pointers and count at 0, entries zeroed, so awaddr=0 and wdata=0.
- Mid-operation reset discards all entries and any in-flight transaction immediately. No AXI valid stays high.
- st_data_ok pulses in cycle N+1 for a push at the edge ending cycle N.
- Minimum latency with awready=wready=bvalid=1:
  - push at N;
  - awvalid/wvalid high in N+1;
  - bready high in N+2, pop at the end of N+2;
  - wb_empty=1 in N+3 if no other entries.
- Back-to-back drain: the next awvalid rises in the cycle after the pop, with no IDLE bubble.
- awvalid/wvalid must not drop, and the AW/W payload must not change, until the respective ready is sampled high.

## Structure
- Shared package: AXI constants (burst INCR, size encodings, len 0, OKAY), the drain FSM state enum, and the store-entry struct.
- Sub-module wr_fifo: storage, pointers, count, full/empty, and the parallel address-compare output.
- The top level holds the drain FSM, the aw_done/w_done flags, bus_err and the AXI field drive.

## Test plan
- Single word store 0x1000_0040 / 0xDEADBEEF, wstrb F, all readies 1 → st_data_ok at N+1; AW/W at N+1 with awsize=2, wlast=1; pop at N+2; wb_empty=1 at N+3.
- Five pushes with awready=0 (DEPTH=4) → st_addr_ok=0 after the fourth push; the fifth is held until the first B. Drain order equals push order.
- AW and W ready skewed: wready at N+1, awready at N+4 → wvalid drops after N+1; awvalid held with awaddr stable through N+4; bready only after N+4.
- Buffered store to 0x2000_0104; chk_addr=0x2000_0106 → chk_hit=1. chk_addr=0x2000_0108 → chk_hit=0. chk_hit clears in the cycle after the B handshake.
- bresp=2'b10 on the first of two stores → bus_err sets and stays 1; the second store still drains.
- aresetn low while in WAIT_B with 3 entries → awvalid/wvalid/bready=0 and wb_empty=1 at once. After release, a new push drains normally.
